// File: rtl/uart_loader_if.sv
// Memory write port from the loader to the core's instruction/data memory.
// Loader drives a one-cycle strobe; the memory has no backpressure.
interface uart_loader_if #(
    parameter int ADDR_W = 12
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/uart_loader.sv
// UART 8N1 program loader: length header + little-endian words into memory, then releases cpu_hold.
// Write strobe fires one cycle after the last byte of each word; no backpressure (memory must accept every strobe).
module uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MEM_WORDS    = 2056,
    parameter int ADDR_W       = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ser_rx,
    uart_loader_if.master   mem,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE, L_ERR} ld_state_t;

    logic rx_meta, rx;

    rx_state_t r_st, r_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    sh, sh_nxt;
    logic          byte_valid, bv_nxt;
    logic          frame_bad, fb_nxt;

    ld_state_t l_st, l_nxt;
    logic [1:0]        bc, bc_nxt;
    logic [23:0]       asm_q, asm_nxt;
    logic [31:0]       len, len_nxt;
    logic [ADDR_W-1:0] idx, idx_nxt;
    logic              we, we_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [31:0]       wdata, wdata_nxt;
    logic [31:0]       full_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
        end else begin
            rx_meta <= ser_rx;
            rx      <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_st       <= R_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            byte_valid <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            r_st       <= r_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_nxt;
            sh         <= sh_nxt;
            byte_valid <= bv_nxt;
            frame_bad  <= fb_nxt;
        end
    end

    // Sampling points: mid start bit, then one bit period apart.
    always_comb begin
        r_nxt   = r_st;
        cnt_nxt = cnt + 1'b1;
        bit_nxt = bit_cnt;
        sh_nxt  = sh;
        bv_nxt  = 1'b0;
        fb_nxt  = 1'b0;
        case (r_st)
            R_IDLE: begin
                cnt_nxt = '0;
                if (!rx) begin
                    r_nxt   = R_START;
                    bit_nxt = '0;
                end
            end
            R_START: begin
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    r_nxt   = rx ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    sh_nxt  = {rx, sh[7:1]};
                    bit_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        r_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    r_nxt   = R_IDLE;
                    bv_nxt  = rx;
                    fb_nxt  = !rx;
                end
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            l_st  <= L_LEN;
            bc    <= '0;
            asm_q <= '0;
            len   <= '0;
            idx   <= '0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            l_st  <= l_nxt;
            bc    <= bc_nxt;
            asm_q <= asm_nxt;
            len   <= len_nxt;
            idx   <= idx_nxt;
            we    <= we_nxt;
            addr  <= addr_nxt;
            wdata <= wdata_nxt;
        end
    end

    assign full_word = {sh, asm_q};

    // Header and data words share one byte shifter; bc wraps every 4 bytes.
    always_comb begin
        l_nxt     = l_st;
        bc_nxt    = bc;
        asm_nxt   = asm_q;
        len_nxt   = len;
        idx_nxt   = idx;
        we_nxt    = 1'b0;
        addr_nxt  = addr;
        wdata_nxt = wdata;
        case (l_st)
            L_LEN: begin
                if (byte_valid) begin
                    bc_nxt  = bc + 2'd1;
                    asm_nxt = {sh, asm_q[23:8]};
                    if (bc == 2'd3) begin
                        len_nxt = full_word;
                        idx_nxt = '0;
                        if (full_word == 32'd0)
                            l_nxt = L_DONE;
                        else if (full_word > 32'(MEM_WORDS))
                            l_nxt = L_ERR;
                        else
                            l_nxt = L_DATA;
                    end
                end
                if (frame_bad)
                    l_nxt = L_ERR;
            end
            L_DATA: begin
                if (we) begin
                    idx_nxt = idx + 1'b1;
                    if (32'(idx) == len - 32'd1)
                        l_nxt = L_DONE;
                end
                if (byte_valid) begin
                    bc_nxt  = bc + 2'd1;
                    asm_nxt = {sh, asm_q[23:8]};
                    if (bc == 2'd3) begin
                        we_nxt    = 1'b1;
                        addr_nxt  = idx;
                        wdata_nxt = full_word;
                    end
                end
                if (frame_bad)
                    l_nxt = L_ERR;
            end
            L_DONE:  l_nxt = L_DONE;
            L_ERR:   l_nxt = L_ERR;
            default: l_nxt = L_ERR;
        endcase
    end

    assign mem.mem_we    = we;
    assign mem.mem_addr  = addr;
    assign mem.mem_wdata = wdata;
    assign cpu_hold      = (l_st != L_DONE);
    assign load_done     = (l_st == L_DONE);
    assign load_err      = (l_st == L_ERR);
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial stimulus, expected writes queued and checked as they appear.
module tb_uart_loader;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ser_rx = 1'b1;
    logic cpu_hold, load_done, load_err;

    uart_loader_if #(.ADDR_W(12)) mem_if();

    uart_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(2056), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .ser_rx(ser_rx), .mem(mem_if),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        bit          last;
    } wr_t;

    wr_t sb[$];
    int tests = 0;
    int fails = 0;
    int we_cnt = 0;
    int cyc = 0;
    int stop_t = 0;
    int done_rise = -1;
    bit done_chk = 0;
    logic done_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done_chk) begin
            chk("done_after_last", 32'(load_done), 32'd1);
            chk("hold_after_last", 32'(cpu_hold), 32'd0);
            done_chk = 0;
        end
        if (load_done && !done_prev) done_rise = cyc;
        done_prev = load_done;
        if (!reset && mem_if.mem_we) begin
            we_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_we observed write addr=%h data=%h expected none",
                       mem_if.mem_addr, mem_if.mem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_if.mem_addr), 32'(e.addr));
                chk("wr_data", mem_if.mem_wdata, e.data);
                chk("done_during_wr", 32'(load_done), 32'd0);
                if (e.last) done_chk = 1;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) ser_rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) ser_rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) ser_rx = stop;
        stop_t = cyc;
        repeat (CPB - 1) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic exp_wr(input logic [11:0] a, input logic [31:0] d, input bit last);
        wr_t e;
        e.addr = a; e.data = d; e.last = last;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        ser_rx = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        we_cnt = 0;
        done_rise = -1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_we", 32'(mem_if.mem_we), 32'd0);
        chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst_wdata", mem_if.mem_wdata, 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Two-word image
        exp_wr(12'd0, 32'h0000_0513, 0);
        exp_wr(12'd1, 32'h0010_0093, 1);
        send_word(32'd2);
        send_word(32'h0000_0513);
        chk("t1_hold_mid", 32'(cpu_hold), 32'd1);
        send_word(32'h0010_0093);
        repeat (20) @(negedge clk);
        chk("t1_sb_empty", 32'(sb.size()), 32'd0);
        chk("t1_we_count", 32'(we_cnt), 32'd2);
        chk("t1_done", 32'(load_done), 32'd1);
        chk("t1_hold", 32'(cpu_hold), 32'd0);
        chk("t1_addr_hold", 32'(mem_if.mem_addr), 32'd1);
        chk("t1_wdata_hold", mem_if.mem_wdata, 32'h0010_0093);
        send_word(32'hDEAD_BEEF);
        repeat (20) @(negedge clk);
        chk("t1_ignore_after_done", 32'(we_cnt), 32'd2);

        // Zero-length image
        do_reset();
        for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
        chk("t2_done_early", 32'(load_done), 32'd0);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        chk("t2_done", 32'(load_done), 32'd1);
        chk("t2_hold", 32'(cpu_hold), 32'd0);
        chk("t2_rise_in_stop", 32'(done_rise > stop_t && done_rise <= stop_t + CPB), 32'd1);
        chk("t2_no_we", 32'(we_cnt), 32'd0);

        // Short glitch is a false start; header still decodes as N=1
        do_reset();
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        exp_wr(12'd0, 32'h1234_5678, 1);
        send_word(32'd1);
        send_word(32'h1234_5678);
        repeat (20) @(negedge clk);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);
        chk("t3_done", 32'(load_done), 32'd1);
        chk("t3_we_count", 32'(we_cnt), 32'd1);

        // Framing error on a data byte
        do_reset();
        send_word(32'd1);
        send_byte(8'h55, 1'b0);
        repeat (4) @(negedge clk);
        chk("t4_err", 32'(load_err), 32'd1);
        chk("t4_hold", 32'(cpu_hold), 32'd1);
        send_word(32'hAABB_CCDD);
        repeat (20) @(negedge clk);
        chk("t4_no_we", 32'(we_cnt), 32'd0);
        chk("t4_done", 32'(load_done), 32'd0);

        // Length just over the memory depth
        do_reset();
        send_word(32'd2057);
        repeat (4) @(negedge clk);
        chk("t5_err", 32'(load_err), 32'd1);
        chk("t5_done", 32'(load_done), 32'd0);
        send_word(32'h1111_2222);
        repeat (20) @(negedge clk);
        chk("t5_no_we", 32'(we_cnt), 32'd0);

        // Length exactly at the memory depth is accepted
        do_reset();
        send_word(32'd2056);
        repeat (4) @(negedge clk);
        chk("t6_no_err", 32'(load_err), 32'd0);
        chk("t6_not_done", 32'(load_done), 32'd0);

        // Reset in the middle of a load, then a clean reload
        do_reset();
        exp_wr(12'd0, 32'h0000_0513, 0);
        send_word(32'd2);
        send_word(32'h0000_0513);
        send_byte(8'h93, 1'b1);
        send_byte(8'h00, 1'b1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("t7_rst_we", 32'(mem_if.mem_we), 32'd0);
        chk("t7_rst_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("t7_rst_wdata", mem_if.mem_wdata, 32'd0);
        chk("t7_rst_hold", 32'(cpu_hold), 32'd1);
        chk("t7_rst_done", 32'(load_done), 32'd0);
        chk("t7_rst_err", 32'(load_err), 32'd0);
        reset = 1'b0;
        we_cnt = 0;
        exp_wr(12'd0, 32'h0000_0513, 0);
        exp_wr(12'd1, 32'h0010_0093, 1);
        send_word(32'd2);
        send_word(32'h0000_0513);
        send_word(32'h0010_0093);
        repeat (20) @(negedge clk);
        chk("t7_sb_empty", 32'(sb.size()), 32'd0);
        chk("t7_we_count", 32'(we_cnt), 32'd2);
        chk("t7_done", 32'(load_done), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
